pipelined_instruction_decoder: RTL and testbench

Registered, parametrised instruction decode stage for the datapath/microsequencer pair. Decodes the MB/op/MD/FS/BC/DA/AA/BA instruction format for any register-file depth. Adds a valid/ready handshake on both sides, a write scoreboard that holds back read-after-write and write-after-write hazards, and a flush input for taken branches. Sits between instruction fetch and the register file/function unit.

---
 rtl/pipelined_instruction_decoder_if.sv | 45 ++++
 rtl/pipelined_instruction_decoder.sv | 129 ++++++++++++
 tb/tb_pipelined_instruction_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_instruction_decoder_if.sv
// pipelined_instruction_decoder_if
//   Bundles the decoder's fetch-side, issue-side and writeback signals.
//   master : instruction source / consumer / writeback side (drives
//            flush, in_valid, in_instr, out_ready, wb_valid, wb_addr)
//   slave  : the decoder (drives in_ready, out_valid and decoded fields)
//   Signals:
//     flush, in_valid, in_ready, in_instr[INSTR_W-1:0]  fetch handshake
//     out_valid, out_ready                               issue handshake
//     DA, AA, BA, MB, FS, MD, JB, RW, MW, PL, BC          decoded fields
//     wb_valid, wb_addr                                  register writeback
interface pipelined_instruction_decoder_if #(
   parameter int REG_AW = 2
);
   localparam int INSTR_W = 7 + 3*REG_AW;

   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic               out_valid;
   logic               out_ready;
   logic [REG_AW-1:0]  DA;
   logic [REG_AW-1:0]  AA;
   logic [REG_AW-1:0]  BA;
   logic               MB;
   logic [3:0]         FS;
   logic               MD;
   logic               JB;
   logic               RW;
   logic               MW;
   logic               PL;
   logic               BC;
   logic               wb_valid;
   logic [REG_AW-1:0]  wb_addr;

   modport master (
      output flush, in_valid, in_instr, out_ready, wb_valid, wb_addr,
      input  in_ready, out_valid, DA, AA, BA, MB, FS, MD, JB, RW, MW, PL, BC
   );

   modport slave (
      input  flush, in_valid, in_instr, out_ready, wb_valid, wb_addr,
      output in_ready, out_valid, DA, AA, BA, MB, FS, MD, JB, RW, MW, PL, BC
   );
endinterface

// File: rtl/pipelined_instruction_decoder.sv
// pipelined_instruction_decoder
//   Registered instruction decode stage with valid/ready handshakes, a
//   per-register write scoreboard holding back RAW/WAW hazards, and a
//   flush input for taken branches.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   pipelined_instruction_decoder_if.slave (fetch handshake,
//           issue handshake, decoded fields, writeback)
//     issue_cnt[15:0], stall_cnt[15:0]  saturating performance counters,
//           present only when DECODE_PERF_CNT_EN is defined
//   Macro: DECODE_PERF_CNT_EN enables the performance counters.
module pipelined_instruction_decoder #(
   parameter int REG_AW = 2
) (
   input  logic clk,
   input  logic rst,
   pipelined_instruction_decoder_if.slave bus
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [15:0] issue_cnt,
   output logic [15:0] stall_cnt
`endif
);
   localparam int INSTR_W = 7 + 3*REG_AW;
   localparam int NREG    = 2**REG_AW;

   // combinational decode of the incoming word
   logic              mb_d, op_d, md_d, bc_d, rw_d, mw_d, pl_d;
   logic [3:0]        fs_d;
   logic [REG_AW-1:0] da_d, aa_d, ba_d;

   always_comb begin
      mb_d = bus.in_instr[INSTR_W-1];
      op_d = bus.in_instr[INSTR_W-2];
      md_d = bus.in_instr[INSTR_W-3];
      bc_d = bus.in_instr[3*REG_AW];
      da_d = bus.in_instr[3*REG_AW-1 -: REG_AW];
      aa_d = bus.in_instr[2*REG_AW-1 -: REG_AW];
      ba_d = bus.in_instr[REG_AW-1:0];
      rw_d = ~op_d;
      mw_d = op_d & ~mb_d;
      pl_d = op_d & mb_d;
      fs_d = {bus.in_instr[INSTR_W-4 -: 3], bc_d & ~pl_d};
   end

   // holding register
   logic              hold_valid;
   logic              mb_q, md_q, bc_q, rw_q, mw_q, pl_q;
   logic [3:0]        fs_q;
   logic [REG_AW-1:0] da_q, aa_q, ba_q;
   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pend_eff;
   logic              hazard, out_valid, issue, in_ready, accept;

   // a writeback retiring this cycle already unblocks the held instruction
   always_comb begin
      pend_eff = pending;
      if (bus.wb_valid) pend_eff[bus.wb_addr] = 1'b0;
   end

   assign hazard    = pend_eff[aa_q] | (~mb_q & pend_eff[ba_q]) | (rw_q & pend_eff[da_q]);
   assign out_valid = hold_valid & ~hazard;
   assign issue     = out_valid & bus.out_ready;
   assign in_ready  = ~bus.flush & (~hold_valid | issue);
   assign accept    = bus.in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         mb_q       <= 1'b0;
         md_q       <= 1'b0;
         bc_q       <= 1'b0;
         rw_q       <= 1'b0;
         mw_q       <= 1'b0;
         pl_q       <= 1'b0;
         fs_q       <= '0;
         da_q       <= '0;
         aa_q       <= '0;
         ba_q       <= '0;
         pending    <= '0;
      end else begin
         if (accept) begin
            hold_valid <= 1'b1;
            mb_q       <= mb_d;
            md_q       <= md_d;
            bc_q       <= bc_d;
            rw_q       <= rw_d;
            mw_q       <= mw_d;
            pl_q       <= pl_d;
            fs_q       <= fs_d;
            da_q       <= da_d;
            aa_q       <= aa_d;
            ba_q       <= ba_d;
         end else if (issue || bus.flush) begin
            hold_valid <= 1'b0;
         end
         // set after clear so an issue to the same register wins
         if (bus.wb_valid) pending[bus.wb_addr] <= 1'b0;
         if (issue && rw_q) pending[da_q] <= 1'b1;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.DA        = da_q;
   assign bus.AA        = aa_q;
   assign bus.BA        = ba_q;
   assign bus.MB        = mb_q;
   assign bus.FS        = fs_q;
   assign bus.MD        = md_q;
   assign bus.JB        = md_q;
   assign bus.RW        = rw_q;
   assign bus.MW        = mw_q;
   assign bus.PL        = pl_q;
   assign bus.BC        = bc_q;

`ifdef DECODE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (issue && issue_cnt != '1) issue_cnt <= issue_cnt + 16'd1;
         if (hold_valid && hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
module tb_pipelined_instruction_decoder;
   localparam int REG_AW  = 2;
   localparam int INSTR_W = 13;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_instruction_decoder_if #(.REG_AW(REG_AW)) bus ();

`ifdef DECODE_PERF_CNT_EN
   logic [15:0] issue_cnt;
   logic [15:0] stall_cnt;
`endif

   pipelined_instruction_decoder #(.REG_AW(REG_AW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef DECODE_PERF_CNT_EN
      ,
      .issue_cnt(issue_cnt),
      .stall_cnt(stall_cnt)
`endif
   );

   typedef struct {
      int da; int aa; int ba; int mb; int fs; int md; int rw; int mw; int pl; int bc;
   } dec_t;

   typedef struct {
      int   instr;
      dec_t exp;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   vec_t vt[6];
   dec_t d_zero, d_0008, d;

   // random-phase reference state
   bit   m_hold;
   int   m_word;
   bit   pend[4];
   bit   pe[4];
   int   m_issue, m_stall;
   bit   haz, e_ov, e_ir;
   int   iv, ins, ordy, fl, wv, wa;
`ifdef DECODE_PERF_CNT_EN
   int   stall0;
`endif

   function automatic dec_t mkd(int da, int aa, int ba, int mb, int fs, int md,
                                int rw, int mw, int pl, int bc);
      dec_t r;
      r.da = da; r.aa = aa; r.ba = ba; r.mb = mb; r.fs = fs;
      r.md = md; r.rw = rw; r.mw = mw; r.pl = pl; r.bc = bc;
      return r;
   endfunction

   function automatic vec_t mkv(int instr, dec_t e);
      vec_t v;
      v.instr = instr;
      v.exp   = e;
      return v;
   endfunction

   // instruction word -> fields, straight from the field map and equations
   function automatic dec_t decode(int w);
      dec_t r;
      int   op;
      r.mb = (w >> 12) & 1;
      op   = (w >> 11) & 1;
      r.md = (w >> 10) & 1;
      r.bc = (w >> 6) & 1;
      r.da = (w >> 4) & 3;
      r.aa = (w >> 2) & 3;
      r.ba = w & 3;
      r.rw = 1 - op;
      r.mw = op * (1 - r.mb);
      r.pl = op * r.mb;
      r.fs = ((w >> 7) & 7) * 2 + r.bc * (1 - r.pl);
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_fields(input string name, input dec_t e);
      chk({name, ".DA"}, int'(bus.DA), e.da);
      chk({name, ".AA"}, int'(bus.AA), e.aa);
      chk({name, ".BA"}, int'(bus.BA), e.ba);
      chk({name, ".MB"}, int'(bus.MB), e.mb);
      chk({name, ".FS"}, int'(bus.FS), e.fs);
      chk({name, ".MD"}, int'(bus.MD), e.md);
      chk({name, ".JB"}, int'(bus.JB), e.md);
      chk({name, ".RW"}, int'(bus.RW), e.rw);
      chk({name, ".MW"}, int'(bus.MW), e.mw);
      chk({name, ".PL"}, int'(bus.PL), e.pl);
      chk({name, ".BC"}, int'(bus.BC), e.bc);
   endtask

   // drive all inputs, then let combinational outputs settle
   task automatic drive(input int i_v, input int i_ins, input int o_r,
                        input int f, input int w_v, input int w_a);
      bus.in_valid  = (i_v != 0);
      bus.in_instr  = INSTR_W'(i_ins);
      bus.out_ready = (o_r != 0);
      bus.flush     = (f != 0);
      bus.wb_valid  = (w_v != 0);
      bus.wb_addr   = REG_AW'(w_a);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      d_zero = mkd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      d_0008 = mkd(0, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      vt[0] = mkv('h05A7, mkd(2, 1, 3, 0,  6, 1, 1, 0, 0, 0));
      vt[1] = mkv('h1AD8, mkd(1, 2, 0, 1, 10, 0, 0, 0, 1, 1));
      vt[2] = mkv('h0FF2, mkd(3, 0, 2, 0, 15, 1, 0, 1, 0, 1));
      vt[3] = mkv('h104D, mkd(0, 3, 1, 1,  1, 0, 1, 0, 0, 1));
      vt[4] = mkv('h0000, mkd(0, 0, 0, 0,  0, 0, 1, 0, 0, 0));
      vt[5] = mkv('h1FFF, mkd(3, 3, 3, 1, 14, 1, 0, 0, 1, 1));

      // reset state
      do_reset();
      chk("rst.out_valid", int'(bus.out_valid), 0);
      chk("rst.in_ready", int'(bus.in_ready), 1);
      chk_fields("rst", d_zero);

      // table: accept, decode/issue, clean up scoreboard
      for (int i = 0; i < 6; i++) begin
         drive(1, vt[i].instr, 1, 0, 0, 0);
         chk("tbl.in_ready", int'(bus.in_ready), 1);
         tick();
         drive(0, 0, 1, 0, 0, 0);
         chk("tbl.out_valid", int'(bus.out_valid), 1);
         chk_fields($sformatf("tbl%0d", i), vt[i].exp);
         tick();
         drive(0, 0, 1, 0, vt[i].exp.rw, vt[i].exp.da);
         chk("tbl.idle", int'(bus.out_valid), 0);
         tick();
      end

      // RAW hazard with same-cycle writeback bypass
      drive(1, 'h05A7, 1, 0, 0, 0);
      tick();
      drive(1, 'h0008, 1, 0, 0, 0);
      chk("raw.first_valid", int'(bus.out_valid), 1);
      chk("raw.back_to_back", int'(bus.in_ready), 1);
`ifdef DECODE_PERF_CNT_EN
      stall0 = int'(stall_cnt);
`endif
      for (int n = 0; n < 4; n++) begin
         tick();
         drive(0, 0, 1, 0, 0, 0);
         chk("raw.stall_valid", int'(bus.out_valid), 0);
         chk("raw.stall_ready", int'(bus.in_ready), 0);
      end
      tick();
      drive(0, 0, 1, 0, 1, 2);
      chk("raw.bypass_valid", int'(bus.out_valid), 1);
      chk_fields("raw", d_0008);
`ifdef DECODE_PERF_CNT_EN
      chk("raw.stall_cnt", int'(stall_cnt) - stall0, 4);
`endif
      tick();
      drive(0, 0, 1, 0, 1, 0);
      chk("raw.after", int'(bus.out_valid), 0);
      tick();

      // backpressure
      drive(1, 'h0FF2, 0, 0, 0, 0);
      chk("bp.accept1", int'(bus.in_ready), 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         drive(1, 'h1AD8, 0, 0, 0, 0);
         chk("bp.hold_valid", int'(bus.out_valid), 1);
         chk("bp.hold_ready", int'(bus.in_ready), 0);
         chk_fields("bp.held", vt[2].exp);
      end
      tick();
      drive(1, 'h1AD8, 1, 0, 0, 0);
      chk("bp.release_valid", int'(bus.out_valid), 1);
      chk("bp.release_ready", int'(bus.in_ready), 1);
      chk_fields("bp.first", vt[2].exp);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      chk("bp.second_valid", int'(bus.out_valid), 1);
      chk_fields("bp.second", vt[1].exp);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      chk("bp.no_dup", int'(bus.out_valid), 0);
      tick();

      // branch with BA pending; branch must not touch the scoreboard
      drive(1, 'h0000, 1, 0, 0, 0);
      tick();
      drive(1, 'h1AD8, 1, 0, 0, 0);
      chk("br.setup", int'(bus.out_valid), 1);
      tick();
      drive(1, 'h1804, 1, 0, 0, 0);
      chk("br.valid", int'(bus.out_valid), 1);
      chk_fields("br", vt[1].exp);
      tick();
      drive(1, 'h1800, 1, 0, 0, 0);
      chk("br.no_set_r1", int'(bus.out_valid), 1);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      chk("br.r0_still_pending", int'(bus.out_valid), 0);
      tick();
      drive(0, 0, 1, 0, 1, 0);
      chk("br.r0_released", int'(bus.out_valid), 1);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      tick();

      // flush of a stalled instruction
      drive(1, 'h05A7, 1, 0, 0, 0);
      tick();
      drive(1, 'h0008, 1, 0, 0, 0);
      tick();
      drive(1, 'h0000, 1, 1, 0, 0);
      chk("fl.stalled", int'(bus.out_valid), 0);
      chk("fl.in_ready", int'(bus.in_ready), 0);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      chk("fl.dropped", int'(bus.out_valid), 0);
      chk("fl.ready_after", int'(bus.in_ready), 1);
      drive(1, 'h0008, 1, 0, 0, 0);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      chk("fl.pending_kept", int'(bus.out_valid), 0);
      tick();
      drive(0, 0, 1, 0, 1, 2);
      chk("fl.next_valid", int'(bus.out_valid), 1);
      chk_fields("fl.next", d_0008);
      tick();
      drive(0, 0, 1, 0, 1, 0);
      tick();

      // flush coinciding with issue: issue and its scoreboard set complete
      drive(1, 'h05A7, 1, 0, 0, 0);
      tick();
      drive(0, 0, 1, 1, 0, 0);
      chk("fli.valid", int'(bus.out_valid), 1);
      chk("fli.ready", int'(bus.in_ready), 0);
      tick();
      drive(1, 'h0008, 1, 0, 0, 0);
      chk("fli.cleared", int'(bus.out_valid), 0);
      chk("fli.ready_after", int'(bus.in_ready), 1);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      chk("fli.set_happened", int'(bus.out_valid), 0);

      // reset mid-operation discards hold and scoreboard
      do_reset();
      chk("rst2.out_valid", int'(bus.out_valid), 0);
      chk("rst2.in_ready", int'(bus.in_ready), 1);
      chk_fields("rst2", d_zero);
      drive(1, 'h0008, 1, 0, 0, 0);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      chk("rst2.scoreboard_clear", int'(bus.out_valid), 1);
      tick();

      // randomized run against the reference model
      do_reset();
      m_hold  = 0;
      m_word  = 0;
      m_issue = 0;
      m_stall = 0;
      for (int r = 0; r < 4; r++) pend[r] = 0;
      for (int c = 0; c < 1500; c++) begin
         iv   = ($urandom_range(0, 9) < 7) ? 1 : 0;
         ins  = int'($urandom_range(0, 8191));
         ordy = ($urandom_range(0, 3) != 0) ? 1 : 0;
         fl   = ($urandom_range(0, 19) == 0) ? 1 : 0;
         wv   = ($urandom_range(0, 2) == 0) ? 1 : 0;
         wa   = int'($urandom_range(0, 3));
         drive(iv, ins, ordy, fl, wv, wa);

         pe = pend;
         if (wv != 0) pe[wa] = 0;
         haz = 0;
         if (m_hold) begin
            d   = decode(m_word);
            haz = pe[d.aa] || (d.mb == 0 && pe[d.ba]) || (d.rw == 1 && pe[d.da]);
         end
         e_ov = m_hold && !haz;
         e_ir = (fl == 0) && (!m_hold || (e_ov && ordy != 0));
         chk("rnd.out_valid", int'(bus.out_valid), int'(e_ov));
         chk("rnd.in_ready", int'(bus.in_ready), int'(e_ir));
         if (m_hold) chk_fields("rnd", d);

         if (m_hold && haz) m_stall++;
         if (wv != 0) pend[wa] = 0;
         if (e_ov && ordy != 0) begin
            m_issue++;
            if (d.rw == 1) pend[d.da] = 1;
         end
         if (iv != 0 && e_ir) begin
            m_hold = 1;
            m_word = ins;
         end else if ((e_ov && ordy != 0) || fl != 0) begin
            m_hold = 0;
         end
         tick();
      end
`ifdef DECODE_PERF_CNT_EN
      chk("rnd.issue_cnt", int'(issue_cnt), m_issue);
      chk("rnd.stall_cnt", int'(stall_cnt), m_stall);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
